// File: rtl/core_dmem_responder_if.sv
// LSU data-memory request/response channels (valid/ready on each side).
interface core_dmem_responder_if #(
    parameter int unsigned XLEN = 32
) ();
    localparam int unsigned LANES = XLEN / 8;

    logic             req_valid;
    logic             req_ready;
    logic             req_wen;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_wdata;
    logic [LANES-1:0] req_wmask;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/core_dmem_responder.sv
// Word-organised SRAM responder for LSU loads/stores: one outstanding access, programmable latency.
// Optional address range check with error response when CORE_DMEM_BUS_ERR_EN is defined.
module core_dmem_responder #(
    parameter int unsigned    XLEN       = 32,
    parameter int unsigned    DEPTH_LOG2 = 10,
    parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(32'h8000_0000),
    parameter int unsigned    LATENCY    = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    core_dmem_responder_if.slave bus
);
    localparam int unsigned LANES     = XLEN / 8;
    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W     = 4;
    localparam bit          SKIP_WAIT = (LATENCY <= 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = SKIP_WAIT ? '0 : CNT_W'(LATENCY - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state_q, state_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic             wen_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  wdata_q;
    logic [LANES-1:0] wmask_q;

    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [XLEN-1:0]  rsp_rdata_q;
    logic             rsp_err_q;

    logic             accept_c;
    logic             enter_resp_c;
    logic             acc_wen_c;
    logic [XLEN-1:0]  acc_addr_c;
    logic [XLEN-1:0]  acc_wdata_c;
    logic [LANES-1:0] acc_wmask_c;
    logic [XLEN-1:0]  offset_c;
    logic [DEPTH_LOG2-1:0] idx_c;
    logic             in_range_c;
    logic             acc_err_c;
    logic             addr_unused;

    logic [XLEN-1:0]  mem [DEPTH];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_next = SKIP_WAIT ? RESP : WAIT;
            WAIT:    if (cnt_q == '0)   state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes and latency counter
    always_comb begin
        accept_c     = 1'b0;
        enter_resp_c = 1'b0;
        cnt_next     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_c     = 1'b1;
                    enter_resp_c = SKIP_WAIT;
                    cnt_next     = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) enter_resp_c = 1'b1;
                else             cnt_next     = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase
    end

    // With single-cycle latency the access uses the request being accepted
    assign acc_wen_c   = accept_c ? bus.req_wen   : wen_q;
    assign acc_addr_c  = accept_c ? bus.req_addr  : addr_q;
    assign acc_wdata_c = accept_c ? bus.req_wdata : wdata_q;
    assign acc_wmask_c = accept_c ? bus.req_wmask : wmask_q;

    assign offset_c   = acc_addr_c - BASE_ADDR;
    assign idx_c      = offset_c[DEPTH_LOG2+1:2];
    assign in_range_c = (offset_c[XLEN-1:DEPTH_LOG2+2] == '0);

`ifdef CORE_DMEM_BUS_ERR_EN
    assign acc_err_c   = ~in_range_c;
    assign addr_unused = ^offset_c[1:0];
`else
    assign acc_err_c   = 1'b0;
    assign addr_unused = ^{offset_c[1:0], in_range_c};
`endif

    // Request latch, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_next;
            req_ready_q <= (state_next == IDLE);
            rsp_valid_q <= (state_next == RESP);
            if (accept_c) begin
                wen_q   <= bus.req_wen;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                wmask_q <= bus.req_wmask;
            end
            if (enter_resp_c) begin
                rsp_rdata_q <= (acc_wen_c || acc_err_c) ? '0 : mem[idx_c];
                rsp_err_q   <= acc_err_c;
            end
        end
    end

    // Byte-strobed array write, committed on RESP entry; contents are not reset
    always_ff @(posedge clk) begin
        if (enter_resp_c && acc_wen_c && !acc_err_c) begin
            for (int i = 0; i < LANES; i++) begin
                if (acc_wmask_c[i]) mem[idx_c][i*8 +: 8] <= acc_wdata_c[i*8 +: 8];
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
